// File: rtl/quad_encoder_sampler.sv
// Sweeps every encoder channel on a timer tick or a software trigger and commits
// snapshots plus per-channel deltas atomically; results are read back over an Avalon slave.
module quad_encoder_sampler #(
    parameter int pENCODERS          = 2,
    parameter int pENCODER_PRECISION = 32
) (
    input  logic                                                  iCLOCK,
    input  logic                                                  iRESET,
    input  logic [$clog2(4+2*pENCODERS)-1:0]                      iAVL_ADDRESS,
    input  logic                                                  iAVL_READ,
    output logic [31:0]                                           oAVL_READ_DATA,
    input  logic                                                  iAVL_WRITE,
    input  logic [31:0]                                           iAVL_WRITE_DATA,
    output logic [((pENCODERS > 1) ? $clog2(pENCODERS) : 1)-1:0]  oENC_ADDRESS,
    output logic                                                  oENC_READ,
    input  logic [31:0]                                           iENC_READ_DATA,
    output logic                                                  oIRQ
);

    localparam int EW = (pENCODERS > 1) ? $clog2(pENCODERS) : 1;
    localparam int P  = pENCODER_PRECISION;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;

    state_t        state_reg, state_next;
    logic [EW-1:0] idx_reg, idx_next;
    logic          cap_valid_reg;
    logic [EW-1:0] cap_idx_reg;

    logic          en_reg, irq_en_reg, done_reg, overrun_reg;
    logic [31:0]   period_reg, timer_reg, seq_reg, read_data_reg;

    logic [P-1:0]  shadow_reg [pENCODERS];
    logic [P-1:0]  snap_reg   [pENCODERS];
    logic [P-1:0]  delta_reg  [pENCODERS];
    logic [31:0]   snap_ext   [pENCODERS];
    logic [31:0]   delta_ext  [pENCODERS];

    logic [31:0]   addr_ext, read_mux;
    logic          ctrl_wr, period_wr, status_wr;
    logic          en_rise, tick, trig, req, busy, commit;
    logic          unused_enc_bits;

    assign addr_ext  = 32'(iAVL_ADDRESS);
    assign ctrl_wr   = iAVL_WRITE && (addr_ext == 32'd0);
    assign period_wr = iAVL_WRITE && (addr_ext == 32'd1);
    assign status_wr = iAVL_WRITE && (addr_ext == 32'd2);

    assign en_rise = ctrl_wr && iAVL_WRITE_DATA[0] && !en_reg;
    assign tick    = en_reg && (timer_reg == 32'd0);
    assign trig    = ctrl_wr && iAVL_WRITE_DATA[2];
    assign req     = tick || trig;
    assign busy    = (state_reg != IDLE);
    assign commit  = (state_reg == COMMIT);

    assign oENC_READ      = (state_reg == SCAN);
    assign oENC_ADDRESS   = oENC_READ ? idx_reg : '0;
    assign oAVL_READ_DATA = read_data_reg;
    assign oIRQ           = done_reg && irq_en_reg;
    assign unused_enc_bits = ^iENC_READ_DATA;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next = SCAN;
                    idx_next   = '0;
                end
            end
            SCAN: begin
                if (32'(idx_reg) == 32'(pENCODERS - 1)) state_next = DRAIN;
                else                                    idx_next   = idx_reg + 1'b1;
            end
            DRAIN:   state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            cap_valid_reg <= 1'b0;
            cap_idx_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            // read data returns one cycle after the strobe, so remember which channel it belongs to
            cap_valid_reg <= oENC_READ;
            cap_idx_reg   <= idx_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < pENCODERS; gi++) begin : g_chan
            always_ff @(posedge iCLOCK) begin
                if (iRESET) begin
                    shadow_reg[gi] <= '0;
                    snap_reg[gi]   <= '0;
                    delta_reg[gi]  <= '0;
                end else begin
                    if (cap_valid_reg && (cap_idx_reg == EW'(gi)))
                        shadow_reg[gi] <= iENC_READ_DATA[P-1:0];
                    if (commit) begin
                        delta_reg[gi] <= shadow_reg[gi] - snap_reg[gi];
                        snap_reg[gi]  <= shadow_reg[gi];
                    end
                end
            end
            assign snap_ext[gi]  = 32'(signed'(snap_reg[gi]));
            assign delta_ext[gi] = 32'(signed'(delta_reg[gi]));
        end
    endgenerate

    always_comb begin
        read_mux = '0;
        case (addr_ext)
            32'd0: read_mux = {29'd0, 1'b0, irq_en_reg, en_reg};
            32'd1: read_mux = period_reg;
            32'd2: read_mux = {29'd0, overrun_reg, busy, done_reg};
            32'd3: read_mux = seq_reg;
            default: begin
                for (int i = 0; i < pENCODERS; i++) begin
                    if (addr_ext == 32'(4 + 2*i)) read_mux = snap_ext[i];
                    if (addr_ext == 32'(5 + 2*i)) read_mux = delta_ext[i];
                end
            end
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            en_reg        <= 1'b0;
            irq_en_reg    <= 1'b0;
            period_reg    <= '0;
            timer_reg     <= '0;
            done_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            seq_reg       <= '0;
            read_data_reg <= '0;
        end else begin
            if (ctrl_wr) begin
                en_reg     <= iAVL_WRITE_DATA[0];
                irq_en_reg <= iAVL_WRITE_DATA[1];
            end
            if (period_wr)
                period_reg <= iAVL_WRITE_DATA;

            if (period_wr)      timer_reg <= iAVL_WRITE_DATA;
            else if (en_rise)   timer_reg <= period_reg;
            else if (en_reg)    timer_reg <= (timer_reg == 32'd0) ? period_reg : timer_reg - 32'd1;

            // sticky flags: a set in the same cycle as a W1C clear wins
            done_reg    <= commit || (done_reg && !(status_wr && iAVL_WRITE_DATA[0]));
            overrun_reg <= (req && busy) || (overrun_reg && !(status_wr && iAVL_WRITE_DATA[2]));

            if (commit)
                seq_reg <= seq_reg + 32'd1;
            if (iAVL_READ)
                read_data_reg <= read_mux;
        end
    end

endmodule
